// File: rtl/maxnet_loader.sv
// Collects four operand words for a Maxnet core, pulses core_start, waits for the winner and returns it.
// Optional WAIT timeout with error flag when MAXNET_LOADER_TIMEOUT_EN is defined.
module maxnet_loader #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int SETTLE_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic [31:0] core_inp1,
   output logic [31:0] core_inp2,
   output logic [31:0] core_inp3,
   output logic [31:0] core_inp4,
   output logic        core_start,
   input  logic        core_done,
   input  logic [31:0] core_max,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_err,
   output logic [1:0]  dbg_state
);

   // Handshakes: a word moves when in_valid && in_ready on a rising edge;
   // a result moves when res_valid && res_ready. Valid never depends on ready.

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_START   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESULT  = 2'd3
   } state_t;

   localparam int SW = $clog2(SETTLE_CYCLES + 2);

   if (TIMEOUT_CYCLES < 1 || SETTLE_CYCLES < 0) begin : g_param_guard
      $error("maxnet_loader: TIMEOUT_CYCLES must be >= 1 and SETTLE_CYCLES >= 0");
   end

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    cnt;
   logic [SW-1:0] settle_cnt;
   logic          settled;
   logic          honoured;
   logic          beat;

   assign settled   = (settle_cnt == SW'(SETTLE_CYCLES));
   assign honoured  = (state == S_WAIT) && settled && core_done;
   assign beat      = (state == S_COLLECT) && in_valid;
   assign dbg_state = state;

`ifdef MAXNET_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;
   logic          timeout;

   // to_cnt counts completed WAIT cycles; the TIMEOUT_CYCLES-th one is the last
   assign timeout = (state == S_WAIT) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      core_start = 1'b0;
      res_valid  = 1'b0;
      case (state)
         S_COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && cnt == 2'd3) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            core_start = 1'b1;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            if (honoured) begin
               state_nxt = S_RESULT;
            end
`ifdef MAXNET_LOADER_TIMEOUT_EN
            else if (timeout) begin
               state_nxt = S_RESULT;
            end
`endif
         end
         S_RESULT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_nxt = S_COLLECT;
            end
         end
         default: state_nxt = S_COLLECT;
      endcase
   end

   // Operand slots are written only while collecting, so they stay frozen
   // from START until the machine is back in COLLECT.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 2'd0;
         core_inp1 <= 32'd0;
         core_inp2 <= 32'd0;
         core_inp3 <= 32'd0;
         core_inp4 <= 32'd0;
      end else if (beat) begin
         case (cnt)
            2'd0: core_inp1 <= in_data;
            2'd1: core_inp2 <= in_data;
            2'd2: core_inp3 <= in_data;
            2'd3: core_inp4 <= in_data;
         endcase
         cnt <= (cnt == 2'd3) ? 2'd0 : cnt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
      end else if (state == S_START) begin
         settle_cnt <= '0;
      end else if (state == S_WAIT && !settled) begin
         settle_cnt <= settle_cnt + SW'(1);
      end
   end

`ifdef MAXNET_LOADER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt   <= '0;
         res_data <= 32'd0;
         res_err  <= 1'b0;
      end else begin
         if (state == S_START) begin
            to_cnt <= '0;
         end else if (state == S_WAIT) begin
            to_cnt <= to_cnt + TW'(1);
         end
         // a real answer beats a timeout landing in the same cycle
         if (honoured) begin
            res_data <= core_max;
            res_err  <= 1'b0;
         end else if (timeout) begin
            res_data <= 32'd0;
            res_err  <= 1'b1;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         res_data <= 32'd0;
      end else if (honoured) begin
         res_data <= core_max;
      end
   end

   assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_loader.sv
// Directed bench for maxnet_loader: a core model answers core_start, a scoreboard checks operands and results.
`timescale 1ns/1ps
module tb_maxnet_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic [31:0] core_inp1, core_inp2, core_inp3, core_inp4;
   logic        core_start;
   logic        core_done;
   logic [31:0] core_max = 32'd0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_data;
   logic        res_err;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [32:0]  exp_q[$];
   logic [127:0] exp_inp_q[$];

   // core model controls
   logic        model_done = 1'b0;
   logic        stray_done = 1'b0;
   logic        core_en = 1'b1;
   int          core_delay = 0;
   logic [31:0] core_ret = 32'd0;
   logic        m_armed = 1'b0;
   int          m_cnt = 0;

   // monitor state
   int   cyc = 0;
   int   t4 = 0;
   int   beat_idx = 0;
   int   starts = 0;
   int   chk_lat = 0;
   logic prev_valid = 1'b0;

   assign core_done = model_done | stray_done;

   maxnet_loader #(.TIMEOUT_CYCLES(16), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .core_inp1(core_inp1), .core_inp2(core_inp2), .core_inp3(core_inp3), .core_inp4(core_inp4),
      .core_start(core_start), .core_done(core_done), .core_max(core_max),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
      .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // core model: after core_start waits core_delay cycles, then holds done until the result shows
   always @(negedge clk) begin
      if (rst) begin
         model_done = 1'b0;
         m_armed = 1'b0;
      end else begin
         if (core_start && core_en) begin
            m_armed = 1'b1;
            m_cnt = core_delay;
         end
         if (m_armed) begin
            if (m_cnt == 0) begin
               model_done = 1'b1;
               core_max = core_ret;
               m_armed = 1'b0;
            end else begin
               m_cnt--;
            end
         end
         if (res_valid) model_done = 1'b0;
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         beat_idx = 0;
         prev_valid = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            if (beat_idx == 3) begin
               t4 = cyc;
               beat_idx = 0;
            end else begin
               beat_idx++;
            end
         end
         if (core_start) begin
            starts++;
            if (exp_inp_q.size() == 0) chk("unexpected_core_start", 1, 0);
            else chk("core_inp", {core_inp1, core_inp2, core_inp3, core_inp4}, exp_inp_q.pop_front());
         end
         if (res_valid && !prev_valid && chk_lat != 0) chk("latency", cyc - t4, chk_lat);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else chk("result", {res_err, res_data}, exp_q.pop_front());
         end
         prev_valid = res_valid;
      end
   end

   // driver tasks (called at posedge + 1)
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      int n = 0;
      in_valid = 1'b1;
      in_data = w;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("in_ready_timeout", in_ready, 1'b1);
      sync();
      in_valid = 1'b0;
      repeat (gap) sync();
   endtask

   task automatic send_group(input logic [127:0] g, input int gap);
      logic [127:0] v = g;
      exp_inp_q.push_back(v);
      for (int i = 0; i < 4; i++) send_word(v[127 - 32*i -: 32], gap);
   endtask

   task automatic wait_valid(input int limit);
      int n = 0;
      @(negedge clk);
      while (!res_valid && n < limit) begin
         n++;
         @(negedge clk);
      end
      chk("wait_res_valid", res_valid, 1'b1);
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      @(negedge clk);
      while (exp_q.size() != 0 && n < limit) begin
         n++;
         @(negedge clk);
      end
      chk("drain_timeout", exp_q.size(), 0);
      sync();
   endtask

   initial begin
      int s0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_err", res_err, 1'b0);
      chk("rst_core_start", core_start, 1'b0);
      chk("rst_core_inp", {core_inp1, core_inp2, core_inp3, core_inp4}, 128'd0);
      chk("rst_state", dbg_state, 2'd0);
      sync();

      // back-to-back group, done already high when first honoured
      core_en = 1'b1; core_delay = 0; core_ret = 32'h40400000; chk_lat = 5;
      exp_q.push_back({1'b0, 32'h40400000});
      send_group({32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F000000}, 0);
      wait_drain(100);
      chk("starts_after_first", starts, 1);
      chk_lat = 0;

      // result held under backpressure, stray done and words ignored in RESULT
      res_ready = 1'b0; core_delay = 3; core_ret = 32'hC1200000;
      exp_q.push_back({1'b0, 32'hC1200000});
      send_group({32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004}, 0);
      wait_valid(50);
      sync();
      in_valid = 1'b1; in_data = 32'hDEADBEEF; stray_done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_res_valid", res_valid, 1'b1);
         chk("hold_res_data", res_data, 32'hC1200000);
         chk("hold_in_ready", in_ready, 1'b0);
         sync();
      end
      in_valid = 1'b0; stray_done = 1'b0;
      res_ready = 1'b1;
      wait_drain(20);

      // reset after two words discards the partial group
      send_word(32'hAAAA0001, 0);
      send_word(32'hAAAA0002, 0);
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_inp1", core_inp1, 32'd0);
      chk("post_rst_in_ready", in_ready, 1'b1);
      chk("post_rst_state", dbg_state, 2'd0);
      sync();
      core_delay = 1; core_ret = 32'h41000000;
      exp_q.push_back({1'b0, 32'h41000000});
      send_group({32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003, 32'h41000000}, 0);
      wait_drain(100);

      // gapped beats: one every three cycles
      core_delay = 2; core_ret = 32'h42C80000;
      s0 = starts;
      exp_inp_q.push_back({32'h42C80000, 32'h3DCCCCCD, 32'hBF800000, 32'h00000000});
      send_word(32'h42C80000, 2);
      send_word(32'h3DCCCCCD, 2);
      send_word(32'hBF800000, 2);
      @(negedge clk);
      chk("gap_no_early_start", starts, s0);
      chk("gap_state_collect", dbg_state, 2'd0);
      sync();
      exp_q.push_back({1'b0, 32'h42C80000});
      send_word(32'h00000000, 0);
      wait_drain(100);

      // core_done while collecting is ignored
      stray_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stray_state", dbg_state, 2'd0);
         chk("stray_res_valid", res_valid, 1'b0);
      end
      sync();
      stray_done = 1'b0;

      // core never answers
      core_en = 1'b0;
`ifdef MAXNET_LOADER_TIMEOUT_EN
      chk_lat = 18;
      exp_q.push_back({1'b1, 32'h0});
      send_group({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 0);
      wait_drain(100);
      chk_lat = 0;
`else
      send_group({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 0);
      repeat (1000) @(posedge clk);
      @(negedge clk);
      chk("no_timeout_state_wait", dbg_state, 2'd2);
      chk("no_timeout_res_valid", res_valid, 1'b0);
      sync();
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      chk("recover_state", dbg_state, 2'd0);
      sync();
`endif

      chk("total_starts", starts, 5);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("exp_inp_q_empty", exp_inp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/maxnet_loader.md
MAXNET_LOADER -- requirements
Module: maxnet_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before aborting (used only when MAXNET_LOADER_TIMEOUT_EN is defined).
REQ-002 Parameter: SETTLE_CYCLES, 2, cycles after core_start during which core_done is ignored.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  loader accepts a word this cycle.
REQ-007 in_data  input  32  IEEE-754 single value.
REQ-008 core_inp1..core_inp4  output  32 each  operand words driven to the Maxnet core.
REQ-009 core_start  output  1  one-cycle pulse; core loads operands and begins iterating.
REQ-010 core_done  input  1  core reports a single surviving activation.
REQ-011 core_max  input  32  winning input value from the core.
REQ-012 res_valid  output  1  result word available.
REQ-013 res_ready  input  1  downstream accepts result.
REQ-014 res_data  output  32  captured maximum.
REQ-015 res_err  output  1  result aborted by timeout.

Function
REQ-016 States SHALL be COLLECT, START, WAIT, RESULT; the reset state is COLLECT.
REQ-017 COLLECT: in_ready=1; each in_valid&in_ready beat SHALL be stored at slot index cnt (0->core_inp1 ... 3->core_inp4); cnt increments 0..3.
REQ-018 On the beat with cnt=3, the loader SHALL clear cnt to 0 and move to START on the next edge.
REQ-019 in_ready SHALL be 0 in every state except COLLECT; words presented outside COLLECT are not consumed.
REQ-020 START lasts exactly one cycle with core_start=1, then WAIT; core_inp1..4 SHALL remain stable from the START cycle until the machine returns to COLLECT.
REQ-021 WAIT: a settle counter SHALL mask core_done for SETTLE_CYCLES cycles after START; core_done is honoured only after that.
REQ-022 On the first honoured core_done=1, core_max SHALL be captured into res_data, res_err cleared, and the state SHALL move to RESULT (res_valid=1 on the following cycle).
REQ-023 core_done seen in COLLECT, START, RESULT, or during the settle mask SHALL be ignored.
REQ-024 RESULT: res_valid=1 and res_data/res_err SHALL be held until res_valid&res_ready; then COLLECT on the next edge.
REQ-025 res_ready asserted while res_valid=0 SHALL have no effect.
REQ-026 Minimum latency from the 4th accepted word to res_valid SHALL be 2+SETTLE_CYCLES+1 cycles when core_done is already high when first honoured.
REQ-027 Throughput: the loader SHALL process one group at a time; no new word is accepted until the previous result is consumed.

Reset
REQ-028 When rst=1 on an edge: state=COLLECT, cnt=0, settle/timeout counters=0, core_start=0, res_valid=0, res_err=0, res_data=0, core_inp1..4=0.
REQ-029 Reset SHALL take priority over every handshake; a partially collected group or an in-flight core run SHALL be discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 With MAXNET_LOADER_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; if it reaches TIMEOUT_CYCLES without an honoured core_done, the loader SHALL enter RESULT with res_data=0 and res_err=1.
REQ-032 If a timeout and an honoured core_done occur in the same cycle, core_done SHALL win (res_err=0).
REQ-033 Without MAXNET_LOADER_TIMEOUT_EN, no timeout counter SHALL exist, res_err SHALL be tied to 0, and WAIT SHALL persist until core_done.

Verification
REQ-034 Feed 0x3F800000, 0x40400000, 0x40000000, 0x3F000000 back-to-back; core model returns done with max 0x40400000 -> core_inp1..4 match in order, one core_start pulse, res_data=0x40400000, res_err=0.
REQ-035 core_done held high from the start of WAIT -> ignored for 2 cycles, res_valid rises exactly 5 cycles after the 4th beat.
REQ-036 res_ready held low 10 cycles in RESULT -> res_valid/res_data stable, in_ready=0, in_valid words not consumed.
REQ-037 rst asserted after 2 of 4 words, then 4 new words -> first group discarded, core_inp1 = first post-reset word.
REQ-038 TIMEOUT_EN defined, TIMEOUT_CYCLES=16, core_done never asserted -> RESULT after 16 WAIT cycles with res_data=0, res_err=1; undefined -> still in WAIT after 1000 cycles.
REQ-039 Gapped in_valid (1 beat every 3 cycles) -> group assembled correctly, core_start only after the 4th beat.
